vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates the 640x480@60 raster that feeds the pixel-coordinate inputs of the game/graphics blocks. It produces pix_x/pix_y and the pixel-rate strobe.
- Takes the graphics block's combinational colour back and registers it together with hsync, vsync and data-enable. All four leave the block time-aligned toward the HDMI/VGA encoder.
- Sits between the top-level clock and the game-process and encoder blocks.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 1, clk cycles per pixel (1..15); 1 means a pixel every clk
- SYNC_POL, 0, asserted level of hsync/vsync outputs (0 = active-low)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  synchronous run enable; low holds raster at origin and blanks outputs
- rgb_in  input  3  colour from graphics block for current pix_x/pix_y (combinational upstream)
- pix_en  output  1  one-clk pixel strobe, every CLK_DIV clks
- pix_x  output  10  current horizontal count 0..H_TOTAL-1
- pix_y  output  10  current vertical count 0..V_TOTAL-1
- video_on  output  1  pix_x<H_DISPLAY && pix_y<V_DISPLAY (combinational from counters)
- line_tick  output  1  one-clk pulse on last pixel of each line
- frame_tick  output  1  one-clk pulse on last pixel of each frame
- hsync_out  output  1  registered hsync, aligned with rgb_out
- vsync_out  output  1  registered vsync, aligned with rgb_out
- de_out  output  1  registered data-enable, aligned with rgb_out
- rgb_out  output  3  registered colour, forced 3'b000 when de_out low

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Counters are 10 bit unsigned.
- Reset (async, reset=0) drives the following values:
  - divider=0, pix_x=0, pix_y=0, pix_en=0, line_tick=0, frame_tick=0, de_out=0, rgb_out=0;
  - hsync_out and vsync_out at the deasserted level (~SYNC_POL).
- Reset release takes effect on the next clk edge with no extra pipeline. Reset mid-frame returns everything to origin immediately.
- Divider:
  - Counts 0..CLK_DIV-1 while enable=1.
  - pix_en=1 for exactly the clk cycle where divider==CLK_DIV-1.
  - With CLK_DIV=1, pix_en is constantly 1 while enabled.
- Horizontal counter:
  - On pix_en, pix_x increments.
  - At H_TOTAL-1 it wraps to 0, and pix_y increments.
  - pix_y wraps from V_TOTAL-1 to 0.
- Vertical coverage: pix_y takes every value 0..524, including 481. The game block's refresh tick depends on seeing (pix_y==481, pix_x==0).
- Ticks (combinational, pulse only in a pix_en cycle):
  - line_tick = pix_en && pix_x==H_TOTAL-1;
  - frame_tick = line_tick && pix_y==V_TOTAL-1.
- Raw sync, decoded from the current counters:
  - hsync_raw asserted for pix_x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751;
  - vsync_raw asserted for pix_y in [490, 491], across whole lines.
- Output pipeline (1 pixel latency):
  - On each pix_en, register hsync_raw, vsync_raw, video_on, and (video_on ? rgb_in : 0) into hsync_out, vsync_out, de_out, rgb_out.
  - Between pix_en strobes the output registers hold.
  - Result: rgb_out/de_out/syncs for coordinate (x,y) appear starting the clk after the pix_en in which pix_x==x, pix_y==y. All four stay mutually aligned.
- enable=0 (synchronous), on next clk:
  - divider, pix_x and pix_y cleared to 0;
  - pix_en, line_tick and frame_tick held 0;
  - de_out=0, rgb_out=0, syncs deasserted.
- enable re-asserted: the raster restarts at (0,0). The first pix_en occurs CLK_DIV clks later.
- Simultaneous enable falling and a wrap point: enable wins; no tick is emitted.
- Sync polarity: hsync_out = SYNC_POL when asserted, else ~SYNC_POL (same for vsync_out).

Test Plan:
- Reset behaviour: hold reset=0 for 5 clks, enable=1 -> pix_x=0, pix_y=0, de_out=0, rgb_out=0, hsync_out=vsync_out=1. After release, pix_x=1 on the 1st edge (CLK_DIV=1).
- Line timing: CLK_DIV=1, run one line ->
  - line_tick pulses once per 800 clks;
  - hsync_out low for exactly 96 clks, first low the clk after pix_x==656;
  - de_out high for 640 clks.
- Frame timing: run 2 frames ->
  - frame_tick spacing 420000 clks;
  - vsync_out low for 1600 clks;
  - pix_y==481 && pix_x==0 observed exactly once per frame;
  - pix_y max 524.
- Colour path: rgb_in=3'b011 constant ->
  - rgb_out=3'b011 while de_out=1;
  - rgb_out=3'b000 for pix_x 640..799 and for lines 480..524 (one-pixel latency).
- Pixel divider: CLK_DIV=4 ->
  - pix_en high 1 of every 4 clks;
  - line_tick period 3200 clks;
  - outputs change only the clk after a pix_en.
- Enable and mid-frame reset:
  - deassert enable at pix_x=300, pix_y=200 -> next clk pix_x=0, pix_y=0, de_out=0. Re-enable -> counting resumes from 0.
  - reset pulse at pix_y=400 -> immediate return to reset values.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster/video bundle between the timing generator, the graphics block that
// colours each pixel, and the downstream HDMI/VGA encoder.
interface vga_timing_gen_if;
  logic       enable;
  logic [2:0] rgb_in;
  logic       pix_en;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       line_tick;
  logic       frame_tick;
  logic       hsync_out;
  logic       vsync_out;
  logic       de_out;
  logic [2:0] rgb_out;

  // Generator side
  modport master (
    input  enable, rgb_in,
    output pix_en, pix_x, pix_y, video_on, line_tick, frame_tick,
           hsync_out, vsync_out, de_out, rgb_out
  );

  // Consumer side (graphics block / encoder / testbench)
  modport slave (
    output enable, rgb_in,
    input  pix_en, pix_x, pix_y, video_on, line_tick, frame_tick,
           hsync_out, vsync_out, de_out, rgb_out
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: pixel divider, x/y counters, tick
// decode and a one-pixel output register stage that keeps colour, syncs and
// data-enable aligned toward the encoder.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 1,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic       SYNC_ON  = SYNC_POL;

  logic [3:0] div_q, div_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       de_q, de_d;
  logic [2:0] rgb_q, rgb_d;

  logic pix_en, x_last, y_last, video_on, hs_raw, vs_raw;

  // Strobe is gated by enable and reset so a falling enable (or a held
  // reset) suppresses the pixel step and any tick in that same cycle.
  assign pix_en   = reset & vif.enable & (div_q == DIV_LAST);
  assign x_last   = (x_q == H_LAST);
  assign y_last   = (y_q == V_LAST);
  assign video_on = (x_q < H_VIS) && (y_q < V_VIS);
  assign hs_raw   = (x_q >= HS_BEG) && (x_q < HS_END);
  assign vs_raw   = (y_q >= VS_BEG) && (y_q < VS_END);

  // Divider and raster counters; enable low parks everything at the origin.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (!vif.enable) begin
      div_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else begin
      div_d = pix_en ? 4'd0 : div_q + 4'd1;
      if (pix_en) begin
        if (x_last) begin
          x_d = '0;
          y_d = y_last ? 10'd0 : y_q + 10'd1;
        end else begin
          x_d = x_q + 10'd1;
        end
      end
    end
  end

  // Output stage captures the current pixel's decode on each strobe and
  // holds between strobes, giving one pixel of latency on all four outputs.
  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    de_d  = de_q;
    rgb_d = rgb_q;
    if (!vif.enable) begin
      hs_d  = ~SYNC_ON;
      vs_d  = ~SYNC_ON;
      de_d  = 1'b0;
      rgb_d = 3'b000;
    end else if (pix_en) begin
      hs_d  = hs_raw ? SYNC_ON : ~SYNC_ON;
      vs_d  = vs_raw ? SYNC_ON : ~SYNC_ON;
      de_d  = video_on;
      rgb_d = video_on ? vif.rgb_in : 3'b000;
    end
  end

  // State registers, async clear to the idle raster.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= ~SYNC_ON;
      vs_q  <= ~SYNC_ON;
      de_q  <= 1'b0;
      rgb_q <= 3'b000;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      rgb_q <= rgb_d;
    end
  end

  assign vif.pix_en     = pix_en;
  assign vif.pix_x      = x_q;
  assign vif.pix_y      = y_q;
  assign vif.video_on   = video_on;
  assign vif.line_tick  = pix_en & x_last;
  assign vif.frame_tick = pix_en & x_last & y_last;
  assign vif.hsync_out  = hs_q;
  assign vif.vsync_out  = vs_q;
  assign vif.de_out     = de_q;
  assign vif.rgb_out    = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (full 640x480 with divide-by-1 and
// active-low syncs; a tiny raster with divide-by-4 and active-high syncs)
// driven by shared random enable/reset/colour stimulus. A time-based model
// turns "enabled clocks since restart" into divider phase and pixel index,
// queues the expected observation per clock, and a negedge monitor compares.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       lt;
    logic       ft;
    logic       hs;
    logic       vs;
    logic       de;
    logic [2:0] rgb;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [2:0] rgb_in = 3'b000;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int   HD  = (g == 0) ? 640 : 10;
    localparam int   HF  = (g == 0) ? 16  : 2;
    localparam int   HS  = (g == 0) ? 96  : 3;
    localparam int   HB  = (g == 0) ? 48  : 2;
    localparam int   VD  = (g == 0) ? 480 : 6;
    localparam int   VF  = (g == 0) ? 10  : 1;
    localparam int   VS  = (g == 0) ? 2   : 2;
    localparam int   VB  = (g == 0) ? 33  : 2;
    localparam int   D   = (g == 0) ? 1   : 4;
    localparam logic POL = (g == 0) ? 1'b0 : 1'b1;
    localparam int   HT  = HD + HF + HS + HB;
    localparam int   VT  = VD + VF + VS + VB;

    vga_timing_gen_if vif ();
    assign vif.enable = enable;
    assign vif.rgb_in = rgb_in;

    vga_timing_gen #(
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .CLK_DIV(D), .SYNC_POL(POL)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .vif   (vif.master)
    );

    obs_t       q[$];
    int         t = 0;
    logic       m_hs = ~POL;
    logic       m_vs = ~POL;
    logic       m_de = 1'b0;
    logic [2:0] m_rgb = 3'b000;

    // Reference: t = enabled clocks since restart; pixel index = t / D.
    always @(posedge clk) begin
      int   p, x, y;
      obs_t e;
      if (reset !== 1'b1 || enable !== 1'b1) begin
        t     = 0;
        m_hs  = ~POL;
        m_vs  = ~POL;
        m_de  = 1'b0;
        m_rgb = 3'b000;
      end else begin
        p = t / D;
        x = p % HT;
        y = (p / HT) % VT;
        if (t % D == D - 1) begin
          m_hs  = (x >= HD + HF && x < HD + HF + HS) ? POL : ~POL;
          m_vs  = (y >= VD + VF && y < VD + VF + VS) ? POL : ~POL;
          m_de  = (x < HD) && (y < VD);
          m_rgb = m_de ? rgb_in : 3'b000;
        end
        t++;
      end
      p      = t / D;
      x      = p % HT;
      y      = (p / HT) % VT;
      e.pe   = reset && enable && (t % D == D - 1);
      e.x    = 10'(x);
      e.y    = 10'(y);
      e.von  = (x < HD) && (y < VD);
      e.lt   = e.pe && (x == HT - 1);
      e.ft   = e.lt && (y == VT - 1);
      e.hs   = m_hs;
      e.vs   = m_vs;
      e.de   = m_de;
      e.rgb  = m_rgb;
      q.push_back(e);
    end

    // Monitor: one full-observation comparison per clock, away from the edge.
    always @(negedge clk) begin
      obs_t e, a;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {vif.pix_en, vif.pix_x, vif.pix_y, vif.video_on, vif.line_tick,
             vif.frame_tick, vif.hsync_out, vif.vsync_out, vif.de_out, vif.rgb_out};
        chk($sformatf("inst%0d_obs", g), 64'(a), 64'(e));
      end
    end
  end

  // Async reset must clear the raster without waiting for an edge.
  task automatic pulse_reset_check();
    reset = 1'b0;
    #1;
    chk("async_rst_x0", 64'(g_inst[0].vif.pix_x), 64'd0);
    chk("async_rst_y0", 64'(g_inst[0].vif.pix_y), 64'd0);
    chk("async_rst_de0", 64'(g_inst[0].vif.de_out), 64'd0);
    chk("async_rst_pe0", 64'(g_inst[0].vif.pix_en), 64'd0);
    chk("async_rst_x1", 64'(g_inst[1].vif.pix_x), 64'd0);
    chk("async_rst_y1", 64'(g_inst[1].vif.pix_y), 64'd0);
    chk("async_rst_hs1", 64'(g_inst[1].vif.hsync_out), 64'd0);
  endtask

  initial begin
    // Reset held 5 clocks with enable high.
    repeat (5) @(negedge clk);
    chk("rst_hs0", 64'(g_inst[0].vif.hsync_out), 64'd1);
    chk("rst_vs0", 64'(g_inst[0].vif.vsync_out), 64'd1);
    #2 reset = 1'b1;

    // Release: pix_x must step to 1 on the first edge at divide-by-1.
    @(posedge clk);
    #1 chk("first_step_x0", 64'(g_inst[0].vif.pix_x), 64'd1);

    // Clean run with constant colour, then random colour.
    rgb_in = 3'b011;
    repeat (1700) @(negedge clk);
    repeat (1500) begin
      @(negedge clk);
      #2 rgb_in = 3'($urandom);
    end

    // Directed enable drop, then resume.
    @(negedge clk);
    #2 enable = 1'b0;
    repeat (3) @(negedge clk);
    #2 enable = 1'b1;
    repeat (900) @(negedge clk);

    // Directed mid-run reset.
    #2 pulse_reset_check();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // Random enable drops and occasional resets.
    repeat (6000) begin
      @(negedge clk);
      #2;
      rgb_in = 3'($urandom);
      enable = ($urandom_range(0, 299) != 0);
      if (reset == 1'b0) reset = 1'b1;
      else if ($urandom_range(0, 1999) == 0) pulse_reset_check();
    end

    // Clean tail so the small raster wraps frames uninterrupted.
    @(negedge clk);
    #2 begin enable = 1'b1; reset = 1'b1; end
    repeat (2500) begin
      @(negedge clk);
      #2 rgb_in = 3'($urandom);
    end

    @(negedge clk);
    #1;
    chk("queue_drain0", 64'(g_inst[0].q.size()), 64'd0);
    chk("queue_drain1", 64'(g_inst[1].q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
